// File: rtl/bcd_pkg.sv
// Shared BCD conversion definitions. The reverse direction (BCD -> binary) and
// the forward direction (binary -> BCD) share this package.
//   Types   : conv_state_e (converter FSM states), conv_result_t (result payload)
//   Helpers : nibble_invalid() flags a BCD digit that is above 9
package bcd_pkg;

  localparam int unsigned NIBBLE_W       = 4;
  localparam int unsigned BCD_MAX_NIBBLE = 9;
  localparam int unsigned RES_W          = 8;
  localparam int unsigned BIN_MAX        = 255;

  // Reverse double-dabble: after a right shift, a digit >= 8 gets 3 taken off
  localparam int unsigned ADJ_THRESH     = 8;
  localparam int unsigned ADJ_VAL        = 3;

  // Forward double-dabble: before a left shift, a digit >= 5 gets 3 added
  localparam int unsigned FWD_ADJ_THRESH = 5;
  localparam int unsigned FWD_ADJ_VAL    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    FINISH = 2'd2
  } conv_state_e;

  typedef struct packed {
    logic [RES_W-1:0] bin;
    logic             ovf;
    logic             err;
  } conv_result_t;

  function automatic logic nibble_invalid(input logic [NIBBLE_W-1:0] nib);
    return nib > 4'(BCD_MAX_NIBBLE);
  endfunction

endpackage

// File: rtl/bcd_nibble_sub3.sv
// One digit of a reverse double-dabble step: subtract 3 when the (already
// shifted) digit is 8 or more.
//   i_nibble   : shifted BCD digit
//   o_nibble_c : corrected digit (combinational)
module bcd_nibble_sub3
  import bcd_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_nibble,
  output logic [NIBBLE_W-1:0] o_nibble_c
);

  always_comb begin
    o_nibble_c = i_nibble;
    if (i_nibble >= 4'(ADJ_THRESH)) begin
      o_nibble_c = i_nibble - 4'(ADJ_VAL);
    end
  end

endmodule

// File: rtl/bcd2binary.sv
// Packed BCD to binary converter using iterative reverse double-dabble.
// A conversion takes a fixed 11 clocks from the accepting edge to the done
// cycle, whatever the data. Results saturate at 255 (ovf) and invalid digits
// force a zero result with err.
//   clk, rst_n : clock, async active-low reset
//   start      : conversion request, only looked at in IDLE
//   bcd_in     : {hundreds, tens, ones}, captured on the accepting edge
//   busy       : conversion in progress
//   done       : one-cycle pulse when bin_out/ovf/err are refreshed
//   bin_out    : converted value (saturated)
//   ovf, err   : value above 255 / at least one digit above 9
module bcd2binary
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 3,   // only 3 digits are supported
  parameter int unsigned BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            bin_out,
  output logic                  ovf,
  output logic                  err
);

  localparam int unsigned BCD_W = NIBBLE_W * DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = 4;

  conv_state_e          r_state;
  conv_state_e          w_state_nxt;
  logic [SR_W-1:0]      r_sr;
  logic [SR_W-1:0]      w_sr_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 r_err_q;
  logic                 w_err_q_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  conv_result_t         r_result;
  conv_result_t         w_result_nxt;

  logic [SR_W-1:0]      w_shifted;
  logic [BCD_W-1:0]     w_bcd_adj;
  logic [SR_W-1:0]      w_iter;
  logic                 w_bcd_invalid;
  logic [BIN_W-1:0]     w_value;
  conv_result_t         w_result_fin;

  // One reverse double-dabble iteration: shift right, then fix each digit
  assign w_shifted = r_sr >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_nib
    bcd_nibble_sub3 u_sub3 (
      .i_nibble   (w_shifted[BIN_W + NIBBLE_W*g +: NIBBLE_W]),
      .o_nibble_c (w_bcd_adj[NIBBLE_W*g +: NIBBLE_W])
    );
  end

  assign w_iter = {w_bcd_adj, w_shifted[BIN_W-1:0]};

  // Any digit above 9 poisons the whole conversion
  always_comb begin
    w_bcd_invalid = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (nibble_invalid(bcd_in[NIBBLE_W*i +: NIBBLE_W])) begin
        w_bcd_invalid = 1'b1;
      end
    end
  end

  // Final result formatting: error wins over overflow, overflow saturates
  assign w_value = r_sr[BIN_W-1:0];

  always_comb begin
    w_result_fin.bin = w_value[RES_W-1:0];
    w_result_fin.ovf = 1'b0;
    w_result_fin.err = 1'b0;
    if (r_err_q) begin
      w_result_fin.bin = '0;
      w_result_fin.err = 1'b1;
    end else if (w_value > BIN_W'(BIN_MAX)) begin
      w_result_fin.bin = '1;
      w_result_fin.ovf = 1'b1;
    end
  end

  // Next-state and next-register logic
  always_comb begin
    w_state_nxt  = r_state;
    w_sr_nxt     = r_sr;
    w_cnt_nxt    = r_cnt;
    w_err_q_nxt  = r_err_q;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_result_nxt = r_result;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = CONV;
          w_sr_nxt    = {bcd_in, BIN_W'(0)};
          w_cnt_nxt   = '0;
          w_err_q_nxt = w_bcd_invalid;
          w_busy_nxt  = 1'b1;
        end
      end
      CONV: begin
        w_sr_nxt = w_iter;
        // Counter stops at BIN_W-1; the last iteration hands over to FINISH
        if (r_cnt == CNT_W'(BIN_W - 1)) begin
          w_state_nxt = FINISH;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      FINISH: begin
        w_state_nxt  = IDLE;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b1;
        w_result_nxt = w_result_fin;
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sr     <= '0;
      r_cnt    <= '0;
      r_err_q  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sr     <= w_sr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_err_q  <= w_err_q_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign bin_out = r_result.bin;
  assign ovf     = r_result.ovf;
  assign err     = r_result.err;

endmodule

// File: doc/bcd2binary.md
BCD2BINARY -- requirements
Module: bcd2binary

Interface
REQ-001 SHALL have parameter DIGITS, default 3, number of packed BCD input digits; only 3 is supported.
REQ-002 SHALL have parameter BIN_W, default 10, width of the internal binary accumulator (ceil(log2(10^DIGITS))).
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, conversion request; sampled only in IDLE.
REQ-006 SHALL have port bcd_in, input, 12, digits {hundreds[11:8], tens[7:4], ones[3:0]}; sampled on the accepting edge only.
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1, single-cycle pulse marking new results.
REQ-009 SHALL have port bin_out, output, 8, converted value.
REQ-010 SHALL have port ovf, output, 1, value exceeded 255.
REQ-011 SHALL have port err, output, 1, at least one input nibble was greater than 9.

Function
REQ-012 SHALL use FSM states IDLE, CONV and FINISH.
- IDLE->CONV on start=1.
- CONV->FINISH after BIN_W iterations.
- FINISH->IDLE unconditionally.
REQ-013 On the accepting edge k, SHALL load a 22-bit shift register {bcd_in, 10'b0} and clear the iteration counter.
REQ-013 (cont.) On edge k SHALL also latch err_q = (any nibble > 9).
REQ-014 At each edge k+1..k+10 (CONV), SHALL perform one reverse double-dabble iteration:
- logical right shift of the whole register by 1;
- then subtract 3 from each BCD nibble whose post-shift value is >= 8.
REQ-015 The iteration counter SHALL be 4 bits and SHALL leave CONV on the edge where it reaches BIN_W-1; no wrap is permitted.
REQ-016 At edge k+11 (FINISH), SHALL load the output registers, as follows:
- err_q=1: bin_out=0, ovf=0, err=1.
- Otherwise, value>255: bin_out=8'hFF (saturate), ovf=1, err=0.
- Otherwise: bin_out=value[7:0], ovf=0, err=0.
REQ-017 done SHALL be high for exactly the one cycle following edge k+11, with busy low in that same cycle.
REQ-018 busy SHALL be high from edge k to edge k+11 (11 cycles).
REQ-019 Total latency from the accepting edge to the done cycle SHALL be fixed at 11 clocks, independent of data or error.
REQ-020 start while busy=1 SHALL be ignored, with no queuing.
REQ-021 start high during the done cycle SHALL be accepted, giving back-to-back throughput of one result per 12 cycles.
REQ-022 bin_out, ovf and err SHALL hold their values until the next FINISH and SHALL change at no other time.
REQ-023 A start held high continuously SHALL restart a conversion on every IDLE cycle, re-sampling bcd_in each time.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, shift register=0, counter=0, busy=0, done=0, bin_out=0, ovf=0, err=0.
REQ-025 Reset mid-conversion SHALL abort the conversion with no done pulse; the first start after release SHALL be honoured normally.
REQ-026 rst_n deassertion SHALL be consumed synchronously by the caller's reset synchronizer; the block SHALL contain no reset logic other than the async clear.

Structure
REQ-027 State encodings, BCD_MAX_NIBBLE=9, ADJ_THRESH=8, ADJ_VAL=3 and BIN_MAX=255 SHALL reside in shared package bcd_pkg, alongside the forward-direction constants.
REQ-028 The per-nibble compare-and-subtract-3 SHALL be a sub-module bcd_nibble_sub3, instantiated DIGITS times.
REQ-029 The FSM, counter and output registers SHALL remain in bcd2binary.

Verification
REQ-030 bcd_in=12'h255, start pulse -> done exactly 11 clocks after the accepting edge, bin_out=8'd255, ovf=0, err=0.
REQ-031 bcd_in=12'h256 -> bin_out=8'hFF, ovf=1.
REQ-031 (cont.) bcd_in=12'h999 -> bin_out=8'hFF, ovf=1.
REQ-031 (cont.) bcd_in=12'h000 -> bin_out=0, ovf=0, err=0.
REQ-032 bcd_in=12'h1A3 -> done at same latency, err=1, bin_out=0, ovf=0.
REQ-032 (cont.) A following conversion of 12'h042 -> bin_out=42, err=0.
REQ-033 start re-pulsed at cycles k+3 and k+10 with different bcd_in -> ignored; result matches the first operand and only one done pulse occurs.
REQ-033 (cont.) start held high through the done cycle -> second conversion accepted immediately.
REQ-034 rst_n asserted at cycle k+5 of a conversion of 12'h123 -> all outputs 0 asynchronously, no done pulse.
REQ-034 (cont.) A subsequent conversion of 12'h123 -> bin_out=123.
REQ-035 Exhaustive sweep of all 4096 bcd_in values against a reference model -> correct bin_out/ovf/err for each, with fixed 11-cycle latency.
